mux_n_hs: RTL

//  Parametrised N-channel, WIDTH-bit registered data selector with valid/ready handshake.

---
 rtl/mux_n_hs_if.sv | 27 ++
 rtl/mux_n_hs.sv | 116 +++++++++++
 2 files changed

// File: rtl/mux_n_hs_if.sv
// Stream bundle for mux_n_hs: CH_NUM producer channels in, one consumer stream out.
// master = environment side (producers + consumer), slave = the selector itself.
interface mux_n_hs_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned SEL_W  = $clog2(CH_NUM)
);
  logic [CH_NUM*WIDTH-1:0] in_data;
  logic [CH_NUM-1:0]       in_valid;
  logic [CH_NUM-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch, sel_err
  );
endinterface

// File: rtl/mux_n_hs.sv
// N-channel registered data selector with valid/ready handshake on every channel.
// MODE 0 picks the channel named by sel; MODE 1 round-robins among valid channels.
module mux_n_hs #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned MODE   = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  mux_n_hs_if.slave  bus
);
  localparam int unsigned      SEL_W   = $clog2(CH_NUM);
  localparam logic [SEL_W-1:0] RR_INIT = SEL_W'(CH_NUM - 1);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  rr_last_q, rr_last_d;
  logic              sel_err_q, sel_err_d;

  logic              load_en;
  logic              grant_ok;
  logic [SEL_W-1:0]  grant;
  logic [WIDTH-1:0]  grant_data;
  logic [CH_NUM-1:0] in_ready;
  logic              xfer;

  always_comb begin : grant_logic
    int unsigned idx;
    idx      = 0;
    grant    = '0;
    grant_ok = 1'b0;
    if (MODE == 0) begin
      grant    = bus.sel;
      grant_ok = (32'(bus.sel) < CH_NUM);
    end else begin
      // Scan farthest-first so the nearest valid channel after rr_last is the final winner.
      for (int unsigned k = CH_NUM; k >= 1; k--) begin
        idx = 32'(rr_last_q) + k;
        if (idx >= CH_NUM) idx = idx - CH_NUM;
        if (bus.in_valid[SEL_W'(idx)]) begin
          grant    = SEL_W'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (SEL_W'(i) == grant) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : handshake
    load_en  = !out_valid_q || bus.out_ready;
    in_ready = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      in_ready[i] = load_en && grant_ok && (SEL_W'(i) == grant);
    end
    xfer = |(in_ready & bus.in_valid);
  end

  always_comb begin : next_state
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_last_d   = rr_last_q;
    sel_err_d   = 1'b0;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (MODE != 0) rr_last_d = grant;
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
    // Error flag tracks sel every cycle, independent of stalls.
    if (MODE == 0) sel_err_d = (32'(bus.sel) >= CH_NUM);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_last_q   <= RR_INIT;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_last_q   <= rr_last_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.sel_err   = sel_err_q;

  a_ready_onehot : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    $onehot0(in_ready));

  a_stall_stable : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));

  a_ch_in_range : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    out_valid_q |-> (32'(out_ch_q) < CH_NUM));

  a_rr_no_err : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (MODE != 0) |-> !sel_err_q);
endmodule
